jk_rr_sched: RTL



---
 rtl/jk_sched_pkg.sv | 37 +++
 rtl/jk_rr_sched_arb.sv | 26 ++
 rtl/jk_rr_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/jk_sched_pkg.sv
// Shared types and helpers for the JK cell round-robin scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package jk_sched_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_RESET  = 2'b01,
        CMD_SET    = 2'b10,
        CMD_TOGGLE = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK
    } state_t;

    // {j,k} drive for a command; the encoding was chosen so the bits map directly.
    function automatic logic [1:0] cmd_jk(input cmd_t c);
        return 2'(c);
    endfunction

    // Value the cell must hold after the command, given y at accept time.
    function automatic logic cmd_expect(input cmd_t c, input logic y);
        logic e;
        case (c)
            CMD_RESET:  e = 1'b0;
            CMD_SET:    e = 1'b1;
            CMD_TOGGLE: e = ~y;
            default:    e = y;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/jk_rr_sched_arb.sv
// Two-way round-robin arbiter; prio names the requester favoured on a tie.
// Latency: purely combinational.
// Backpressure: grants nothing while en is low.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Single requester wins outright; a tie goes to the favoured requester.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (en) begin
            case (valid)
                2'b01: begin grant = 2'b01; grant_id = 1'b0; end
                2'b10: begin grant = 2'b10; grant_id = 1'b1; end
                2'b11: begin grant = prio ? 2'b10 : 2'b01; grant_id = prio; end
                default: begin grant = 2'b00; grant_id = 1'b0; end
            endcase
        end
    end

endmodule

// File: rtl/jk_rr_sched.sv
// Round-robin scheduler sharing one JK cell between two command requesters.
// Latency: accept to done is len+2 cycles (len = 1 for TOGGLE, PULSE_LEN otherwise).
// Backpressure: readies only in IDLE; a busy requester holds valid and cmd stable.
import jk_sched_pkg::*;

module jk_rr_sched #(
    parameter int PULSE_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [1:0] req0_cmd,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_cmd,
    output logic       req1_ready,
    output logic       j,
    output logic       k,
    input  logic       y_in,
    output logic       done,
    output logic       done_id,
    output logic       err
);

    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] LAST_LONG = CW'(PULSE_LEN - 1);

    state_t        state_q;
    cmd_t          cmd_q;
    logic          id_q;
    logic          exp_q;
    logic          last_id_q;   // requester served most recently
    logic [CW-1:0] cnt_q;
    logic          j_q, k_q, done_q, done_id_q, err_q;

    logic          arb_en;
    logic [1:0]    grant;
    logic          grant_id;
    cmd_t          cmd_sel;
    logic [CW-1:0] cnt_last;

    assign arb_en = (state_q == S_IDLE) && !reset;

    rr_arb2 u_arb (
        .valid    ({req1_valid, req0_valid}),
        .prio     (~last_id_q),
        .en       (arb_en),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign cmd_sel    = grant_id ? cmd_t'(req1_cmd) : cmd_t'(req0_cmd);
    // TOGGLE must never hold j=k=1 beyond one cycle or the cell would oscillate.
    assign cnt_last   = (cmd_q == CMD_TOGGLE) ? '0 : LAST_LONG;

    // Scheduler FSM: capture on accept, pulse j/k, settle one cycle, then check y.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_HOLD;
            id_q      <= 1'b0;
            exp_q     <= 1'b0;
            last_id_q <= 1'b1;
            cnt_q     <= '0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|grant) begin
                        cmd_q      <= cmd_sel;
                        id_q       <= grant_id;
                        exp_q      <= cmd_expect(cmd_sel, y_in);
                        {j_q, k_q} <= cmd_jk(cmd_sel);
                        cnt_q      <= '0;
                        state_q    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == cnt_last) begin
                        j_q     <= 1'b0;
                        k_q     <= 1'b0;
                        state_q <= S_SETTLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_SETTLE: begin
                    // j=k=0 now, so y_in already shows the cell's final value.
                    done_q    <= 1'b1;
                    done_id_q <= id_q;
                    err_q     <= (y_in != exp_q);
                    state_q   <= S_CHECK;
                end
                default: begin
                    last_id_q <= id_q;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;

endmodule
